// File: rtl/weight_stream_loader.sv
// weight_stream_loader
// Reads a strided block of weight words from the weight buffer, optionally
// replays it for several passes, and streams the words out through a
// valid/ready port. Reads are credit-limited so the output FIFO can never
// overflow, whatever the consumer does.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; config latched on the start cycle
// PRELOAD | preload_req high, waiting for the DMA to report the buffer full
// READ    | issuing buffer reads while credit is available
// DRAIN   | all reads issued; waiting for returns and the FIFO to empty
// FLUSH   | aborted; FIFO cleared, discarding reads still in flight
module weight_stream_loader #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 128,
    parameter int CNT_W      = 17,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int PRELOAD_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] cfg_base_i,
    input  logic [ADDR_W-1:0] cfg_stride_i,
    input  logic [CNT_W-1:0]  cfg_count_i,
    input  logic [7:0]        cfg_repeat_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              done_abort_o,
    output logic              preload_req_o,
    output logic [ADDR_W-1:0] preload_base_o,
    output logic [CNT_W-1:0]  preload_count_o,
    input  logic              preload_done_i,
    output logic              bmg_en_o,
    output logic [ADDR_W-1:0] bmg_addr_o,
    input  logic [DATA_W-1:0] bmg_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {S_IDLE, S_PRELOAD, S_READ, S_DRAIN, S_FLUSH} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d, stride_q, stride_d, addr_q, addr_d;
    logic [CNT_W-1:0]    count_q, count_d, beat_q, beat_d;
    logic [7:0]          repeat_q, repeat_d, pass_q, pass_d;
    logic [RD_LAT-1:0]   en_pipe_q, last_pipe_q;
    logic [CW-1:0]       inflight_q, fcnt_q;
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [DATA_W:0]     fifo_mem_q [FIFO_DEPTH];

    logic issue, issue_last, flush, credit_ok, ret_valid, ret_last, push, pop;

    // credit counts the FIFO occupancy plus every read that is still on its way
    assign credit_ok = ({1'b0, inflight_q} + {1'b0, fcnt_q}) < (CW + 1)'(FIFO_DEPTH);
    assign ret_valid = en_pipe_q[RD_LAT-1];
    assign ret_last  = last_pipe_q[RD_LAT-1];
    assign push      = ret_valid && !flush && (state_q != S_FLUSH);
    assign pop       = out_valid_o && out_ready_i;

    assign busy_o          = (state_q != S_IDLE);
    assign preload_base_o  = base_q;
    assign preload_count_o = count_q;
    assign bmg_en_o        = issue;
    assign bmg_addr_o      = addr_q;
    assign out_valid_o     = (fcnt_q != '0);
    assign out_data_o      = out_valid_o ? fifo_mem_q[rd_ptr_q][DATA_W-1:0] : '0;
    assign out_last_o      = out_valid_o & fifo_mem_q[rd_ptr_q][DATA_W];

    // next-state, read issue and address/beat/pass sequencing
    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        stride_d      = stride_q;
        count_d       = count_q;
        repeat_d      = repeat_q;
        beat_d        = beat_q;
        pass_d        = pass_q;
        addr_d        = addr_q;
        issue         = 1'b0;
        issue_last    = 1'b0;
        flush         = 1'b0;
        done_o        = 1'b0;
        done_abort_o  = 1'b0;
        preload_req_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    base_d   = cfg_base_i;
                    stride_d = cfg_stride_i;
                    count_d  = cfg_count_i;
                    repeat_d = (cfg_repeat_i == 8'd0) ? 8'd1 : cfg_repeat_i;
                    beat_d   = '0;
                    pass_d   = '0;
                    addr_d   = cfg_base_i;
                    if (cfg_count_i == '0)  state_d = S_DRAIN;
                    else if (PRELOAD_EN != 0) state_d = S_PRELOAD;
                    else                      state_d = S_READ;
                end
            end
            S_PRELOAD: begin
                preload_req_o = 1'b1;
                if (abort_i) begin
                    flush   = 1'b1;
                    state_d = S_FLUSH;
                end else if (preload_done_i) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (abort_i) begin
                    flush   = 1'b1;
                    state_d = S_FLUSH;
                end else if (credit_ok) begin
                    issue = 1'b1;
                    if (beat_q == count_q - CNT_W'(1)) begin
                        if (pass_q == repeat_q - 8'd1) begin
                            issue_last = 1'b1;
                            state_d    = S_DRAIN;
                        end else begin
                            beat_d = '0;
                            pass_d = pass_q + 8'd1;
                            addr_d = base_q;
                        end
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                        addr_d = addr_q + stride_q;
                    end
                end
            end
            S_DRAIN: begin
                if (abort_i) begin
                    flush   = 1'b1;
                    state_d = S_FLUSH;
                end else if (inflight_q == '0 && fcnt_q == '0) begin
                    done_o  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (inflight_q == '0) begin
                    done_o       = 1'b1;
                    done_abort_o = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state and latched run configuration/counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            stride_q <= '0;
            count_q  <= '0;
            repeat_q <= '0;
            beat_q   <= '0;
            pass_q   <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            stride_q <= stride_d;
            count_q  <= count_d;
            repeat_q <= repeat_d;
            beat_q   <= beat_d;
            pass_q   <= pass_d;
            addr_q   <= addr_d;
        end
    end

    // read-return pipe matching the buffer latency, plus outstanding-read count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_pipe_q   <= '0;
            last_pipe_q <= '0;
            inflight_q  <= '0;
        end else begin
            en_pipe_q[0]   <= issue;
            last_pipe_q[0] <= issue_last;
            for (int i = 1; i < RD_LAT; i++) begin
                en_pipe_q[i]   <= en_pipe_q[i-1];
                last_pipe_q[i] <= last_pipe_q[i-1];
            end
            inflight_q <= inflight_q + CW'(issue) - CW'(ret_valid);
        end
    end

    // FIFO pointers and occupancy; abort empties it in one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            fcnt_q <= fcnt_q + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; contents are masked at the output while empty
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {ret_last, bmg_data_i};
    end

endmodule
